// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential ALU: operation
//               encodings, FSM state encoding and a signed-overflow helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement overflow. For ADD the operand signs must match, for
    // SUB they must differ; in both cases the result sign must differ from a.
    function automatic logic signed_ovf(input logic i_sa, input logic i_sb,
                                        input logic i_sr, input logic i_is_sub);
        signed_ovf = ((i_sa == i_sb) ^ i_is_sub) && (i_sr != i_sa);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative shift-add unsigned multiplier, one partial product
//               per clock, WIDTH clocks per product.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_start       - load operands and begin (ignored when busy)
//               i_a, i_b      - multiplicand, multiplier
//               o_done        - high in the cycle of the final step
//               o_prod        - accumulator value after the current step;
//                               the full product while o_done is high
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;     // {partial product, remaining multiplier bits}
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;

    // Add the multiplicand into the high half when the multiplier LSB is set,
    // then shift the whole accumulator right with the add carry shifted in.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    assign o_done = r_busy && (r_cnt == CW'(1));
    assign o_prod = w_acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_mcand <= i_a;
            r_acc   <= {{WIDTH{1'b0}}, i_b};
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked ALU. Single-cycle ops (ADD/SUB/AND/OR/XOR/SLT/SLL)
//               complete with latency 1; MUL uses an iterative multiplier and
//               completes WIDTH cycles after accept.
// Ports       : clk, rst              - clock, asynchronous active-high reset
//               in_valid/in_ready     - operand handshake (op, a, b)
//               out_valid/out_ready   - result handshake
//               result, result_hi     - result (MUL: low/high product halves)
//               zero, carry, ovf      - flags for the registered result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);

    state_t             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_zero;
    logic               r_carry;
    logic               r_ovf;

    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;

    assign in_ready    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (op == OP_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_mul_start),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );

    // The extra top bit of the difference is the borrow (a < b unsigned).
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = signed_ovf(a[WIDTH-1], b[WIDTH-1], w_sum[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = signed_ovf(a[WIDTH-1], b[WIDTH-1], w_diff[WIDTH-1], 1'b1);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: w_res = a << b[SHW-1:0];
            default: w_res = '0;   // MUL result comes from the multiplier
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            // Accept is possible from IDLE or from DONE while the consumer
            // takes the current result (back-to-back).
            if (op == OP_MUL) begin
                r_state     <= ST_MUL;
                r_out_valid <= 1'b0;
            end else begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_result_hi <= '0;
                r_zero      <= (w_res == '0);
                r_carry     <= w_carry;
                r_ovf       <= w_ovf;
            end
        end else if ((r_state == ST_MUL) && w_mul_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_prod[WIDTH-1:0];
            r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_zero      <= (w_prod[WIDTH-1:0] == '0);
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if ((r_state == ST_DONE) && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH=8): table of
//               single-cycle vectors plus MUL, back-to-back, back-pressure
//               and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       zero;
    logic       carry;
    logic       ovf;

    int n_chk = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] i_op, input logic [7:0] i_a, input logic [7:0] i_b);
        in_valid = 1'b1;
        op       = i_op;
        a        = i_a;
        b        = i_b;
    endtask

    // Issue a MUL from IDLE and check latency, in_ready and the product.
    task automatic do_mul(input logic [7:0] i_a, input logic [7:0] i_b,
                          input logic [7:0] exp_lo, input logic [7:0] exp_hi);
        int lat;
        drive(3'b111, i_a, i_b);
        tick();
        in_valid = 1'b0;
        a = 8'h00;
        b = 8'h00;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("mul_in_ready_low", {31'd0, in_ready}, 32'd0);
            tick();
            lat++;
        end
        chk("mul_latency", lat, 8);
        chk("mul_lo", {24'd0, result}, {24'd0, exp_lo});
        chk("mul_hi", {24'd0, result_hi}, {24'd0, exp_hi});
        chk("mul_zero", {31'd0, zero}, {31'd0, (exp_lo == 8'h00)});
        chk("mul_carry", {31'd0, carry}, 32'd0);
        tick();
        chk("mul_release", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        //            op      a      b      res    c     v     z
        vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{3'b001, 8'h03, 8'h04, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{3'b010, 8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b011, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b100, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b101, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b101, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{3'b101, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'b110, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b110, 8'h81, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'b110, 8'h03, 8'h0B, 8'h18, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 3'b000;
        a         = 8'h00;
        b         = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, zero, carry, ovf}, 32'd0);

        // Single-cycle table, one op at a time from IDLE.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_result", i), {24'd0, result}, {24'd0, vecs[i].res});
            chk($sformatf("v%0d_hi", i), {24'd0, result_hi}, 32'd0);
            chk($sformatf("v%0d_flags", i), {29'd0, zero, carry, ovf},
                {29'd0, vecs[i].z, vecs[i].c, vecs[i].v});
            tick();
            chk($sformatf("v%0d_drop", i), {31'd0, out_valid}, 32'd0);
        end

        do_mul(8'hFF, 8'hFF, 8'h01, 8'hFE);
        do_mul(8'h00, 8'h37, 8'h00, 8'h00);
        do_mul(8'h80, 8'h02, 8'h00, 8'h01);
        do_mul(8'h0D, 8'h0B, 8'h8F, 8'h00);

        // Back-to-back with out_ready held high: no bubbles.
        drive(3'b100, 8'hF0, 8'h0F);
        tick();
        chk("b2b_xor_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_xor", {24'd0, result}, 32'h0000_00FF);
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        drive(3'b101, 8'h80, 8'h01);
        tick();
        chk("b2b_slt_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_slt", {24'd0, result}, 32'h0000_0001);
        drive(3'b110, 8'h01, 8'h03);
        tick();
        chk("b2b_sll_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_sll", {24'd0, result}, 32'h0000_0008);
        in_valid = 1'b0;
        tick();
        chk("b2b_drop", {31'd0, out_valid}, 32'd0);

        // Back-pressure: result held, new request ignored until out_ready.
        out_ready = 1'b0;
        drive(3'b010, 8'hC3, 8'h5A);
        tick();
        drive(3'b000, 8'h11, 8'h22);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", {24'd0, result}, 32'h0000_0042);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_result", {24'd0, result}, 32'h0000_0033);
        tick();
        chk("bp_drop", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset three cycles into a MUL.
        drive(3'b111, 8'hFF, 8'hFF);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("amid_valid", {31'd0, out_valid}, 32'd0);
        chk("amid_result", {24'd0, result}, 32'd0);
        chk("amid_hi", {24'd0, result_hi}, 32'd0);
        chk("amid_flags", {29'd0, zero, carry, ovf}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("amid_in_ready", {31'd0, in_ready}, 32'd1);
        // Confirm the discarded MUL never surfaces.
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                chk("amid_stale_mul", {31'd0, out_valid}, 32'd0);
            end
            tick();
        end
        drive(3'b000, 8'h02, 8'h03);
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_add", {24'd0, result}, 32'h0000_0005);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the datapath add/sub unit in the 8-bit MIPS core.
- Widens operands to WIDTH bits and adds logic, compare and shift operations.
- Adds an iterative shift-add multiplier taking WIDTH cycles.
- Sits between the register-file read stage and writeback. Uses valid/ready handshakes on input and output, so multi-cycle ops stall the pipeline cleanly.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept an op this cycle.
- op  in  3  operation select (encodings below).
- a  in  WIDTH  operand A (regip).
- b  in  WIDTH  operand B (muxop).
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes result this cycle.
- result  out  WIDTH  result, low half for MUL.
- result_hi  out  WIDTH  MUL high half; 0 for all other ops.
- zero  out  1  result == 0 (low half only).
- carry  out  1  ADD carry-out; SUB borrow (a<b unsigned); 0 otherwise.
- ovf  out  1  signed overflow for ADD/SUB; 0 otherwise.

Behaviour:
- Op encodings:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed a<b gives 1, else 0)
  - 110 SLL (a << b[SHW-1:0])
  - 111 MUL (unsigned a*b, 2*WIDTH product)
- Accept occurs when in_valid && in_ready at a rising edge. Operands and op are captured on accept; later input changes are ignored.
- FSM states: IDLE, MUL, DONE.
  - IDLE -> DONE on accept of a non-MUL op. The result is registered at that edge, so out_valid is high the next cycle (latency 1).
  - IDLE -> MUL on accept of MUL. Multiplicand, multiplier and a counter = WIDTH are loaded.
  - MUL: each cycle, if multiplier LSB is 1, add the multiplicand into the accumulator high half. Then shift {acc} right 1 with carry-in, and decrement the counter. When the counter reaches 1 on that edge, go to DONE. out_valid rises WIDTH cycles after accept.
  - DONE: outputs held stable while out_ready=0.
    - out_ready=1 with in_valid=0 -> IDLE; out_valid drops the next cycle.
    - out_ready=1 with in_valid=1 -> new op accepted the same cycle (back-to-back). Go to DONE or MUL per the new op.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready, with no dependency on in_valid. in_ready is 0 throughout MUL.
- Arithmetic:
  - ADD/SUB use a WIDTH+1-bit sum.
  - ovf = operand signs equal (ADD) / differ (SUB) and result sign differs from a.
  - All results are truncated to WIDTH and wrap modulo 2^WIDTH.
  - SLL shift amounts >= WIDTH cannot occur (SHW bits). Shift of 0 returns a.
- Flags and result_hi are registered together with result and valid only while out_valid=1. While out_valid=0 they hold their last values; the consumer must ignore them.
- Reset, at any time including mid-MUL: state=IDLE, and out_valid, result, result_hi, zero, carry, ovf, counter and accumulator all go to 0. In-flight op is discarded. in_ready=1 after reset deassert.

Decomposition:
- Shared package alu_pkg: op encoding localparams (OP_ADD..OP_MUL), FSM state encoding, and a function for signed-overflow detection.
- One natural sub-module: alu_mul_iter (shift-add multiplier with start/done and counter), instantiated by alu_seq. All single-cycle ops stay in the parent as one combinational case plus result registers.

Test Plan:
- Reset then ADD a=8'h7F b=8'h01 -> 1 cycle later out_valid=1, result=8'h80, ovf=1, carry=0, zero=0.
- SUB a=8'h05 b=8'h05 -> result=0, zero=1, carry=0. Then SUB a=8'h03 b=8'h04 -> result=8'hFF, carry=1, ovf=0.
- MUL a=8'hFF b=8'hFF -> in_ready=0 for 8 cycles. out_valid rises 8 cycles after accept with result=8'h01, result_hi=8'hFE. MUL a=8'h00 b=8'h37 -> result=0, result_hi=0, zero=1.
- Back-to-back with out_ready tied 1: XOR 8'hF0^8'h0F, SLT 8'h80<8'h01, SLL 8'h01<<3 on consecutive cycles -> results 8'hFF, 8'h01, 8'h08 on consecutive cycles, no bubbles.
- Back-pressure: out_ready=0 for 5 cycles after AND 8'hC3&8'h5A -> result=8'h42 held stable, in_ready=0, new in_valid ignored until out_ready=1.
- Assert rst 3 cycles into a MUL -> all outputs 0 immediately (asynchronous). After release in_ready=1, and a following ADD 2+3 yields result=5.
